// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial word receiver.
// SERIAL_RX_PARITY_EN adds the PARITY state to the FSM encoding.
package serial_rx_pkg;

  localparam int WORD_W = 4;
  localparam int CNT_W  = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
`ifdef SERIAL_RX_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_STOP   = 2'd3
  } rx_state_t;

  // Even parity across data and parity bit: a result of 1 means mismatch.
  function automatic logic parity_mismatch(input logic [WORD_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/shift_in_reg.sv
// Serial-in / parallel-out register; bits enter at the MSB and move
// towards the LSB, so the first bit shifted in ends up in bit 0.
module shift_in_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] dout
);

  // Shift one bit per enable; asynchronous clear empties the register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dout <= '0;
    end else if (en) begin
      dout <= {din, dout[W-1:1]};
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Strobe-sampled serial receiver: start bit, WORD_W data bits LSB first,
// optional even parity bit, stop bit. Delivers words through a one-entry
// q/valid holding register with ack-based consumption and sticky error flags.
// Define SERIAL_RX_PARITY_EN to include the parity bit in each frame.
module serial_word_receiver
  import serial_rx_pkg::*;
(
  input  logic              c,
  input  logic              rst,
  input  logic              sin,
  input  logic              bit_en,
  input  logic              ack,
  input  logic              err_clr,
  output logic [WORD_W-1:0] q,
  output logic              valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] word;
  logic              shift_en;
  logic              stop_strobe;
  logic              parity_bad;
  logic              good_word;

`ifdef SERIAL_RX_PARITY_EN
  logic par_bit;
  logic par_err_q;
`endif

  shift_in_reg #(.W(WORD_W)) u_shift (
    .clk  (c),
    .clr  (rst),
    .en   (shift_en),
    .din  (sin),
    .dout (word)
  );

  // Decode the strobe in the current state into shift, stop and delivery events.
  always_comb begin
    shift_en    = bit_en && (state == ST_DATA);
    stop_strobe = bit_en && (state == ST_STOP);
`ifdef SERIAL_RX_PARITY_EN
    parity_bad  = parity_mismatch(word, par_bit);
`else
    parity_bad  = 1'b0;
`endif
    good_word   = stop_strobe && sin && !parity_bad;
  end

  // Frame FSM plus the output holding register and sticky flags; a flag set
  // is written after the clear so a same-cycle error wins over err_clr.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      q         <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bit   <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      if (bit_en) begin
        case (state)
          ST_IDLE: begin
            if (!sin) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
`ifdef SERIAL_RX_PARITY_EN
          ST_PARITY: begin
            par_bit <= sin;
            state   <= ST_STOP;
          end
`endif
          ST_STOP: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end

      if (err_clr) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_err_q <= 1'b0;
`endif
      end

      if (good_word) begin
        if (!valid || ack) begin
          q     <= word;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack && valid) begin
        valid <= 1'b0;
      end

      if (stop_strobe && !sin) begin
        frame_err <= 1'b1;
      end

`ifdef SERIAL_RX_PARITY_EN
      if (stop_strobe && sin && parity_bad) begin
        par_err_q <= 1'b1;
      end
`endif
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
